// File: rtl/fetch_decode_stage_if.sv
// Fetch/decode stage signal bundle: decode control, instruction memory port and IF/ID slot outputs.
// The perf counter signals exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_decode_stage_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_valid;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [3:0]  opcode;
    logic [19:0] imm;
    logic        extend_select;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    modport master (
`ifdef FETCH_PERF_CNT_EN
        output stall_cnt,
        output flush_cnt,
`endif
        input  stall,
        input  branch_taken,
        input  branch_target,
        output imem_req,
        output imem_addr,
        input  imem_data,
        input  imem_valid,
        output valid,
        output pc,
        output instr,
        output opcode,
        output imm,
        output extend_select
    );

    modport slave (
`ifdef FETCH_PERF_CNT_EN
        input  stall_cnt,
        input  flush_cnt,
`endif
        output stall,
        output branch_taken,
        output branch_target,
        input  imem_req,
        input  imem_addr,
        output imem_data,
        output imem_valid,
        input  valid,
        input  pc,
        input  instr,
        input  opcode,
        input  imm,
        input  extend_select
    );
endinterface

// File: rtl/fetch_decode_stage.sv
// Instruction fetch front end with one outstanding imem request, one-entry skid buffer and IF/ID slot.
// Optional stall/flush performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                  clk,
    input logic                  rst,
    fetch_decode_stage_if.master fd
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] fpc_r;
    logic [31:0] ipc_r;
    logic        skid_valid_r;
    logic [31:0] skid_instr_r;
    logic [31:0] skid_pc_r;
    logic        valid_r;
    logic [31:0] instr_r;
    logic [31:0] pc_r;

    logic        slot_free_s;
    logic        accept_s;
    logic        to_slot_s;
    logic        issue_s;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Issue decision and next-state logic; a flush suppresses issue and drops any return
    always_comb begin
        slot_free_s = !valid_r || !fd.stall;
        accept_s    = (state_r == ST_WAIT) && fd.imem_valid && !fd.branch_taken;
        to_slot_s   = accept_s && slot_free_s && !skid_valid_r;
        issue_s     = rst && !fd.branch_taken && !skid_valid_r &&
                      ((state_r == ST_IDLE) || to_slot_s);
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (issue_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (fd.branch_taken) begin
                    state_nxt_s = fd.imem_valid ? ST_IDLE : ST_DRAIN;
                end else if (fd.imem_valid) begin
                    state_nxt_s = issue_s ? ST_WAIT : ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (fd.imem_valid) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Fetch PC, issued-PC tag, skid buffer and IF/ID slot
    always_ff @(posedge clk) begin
        if (!rst) begin
            fpc_r        <= RESET_PC;
            ipc_r        <= 32'h0000_0000;
            skid_valid_r <= 1'b0;
            skid_instr_r <= 32'h0000_0000;
            skid_pc_r    <= 32'h0000_0000;
            valid_r      <= 1'b0;
            instr_r      <= 32'h0000_0000;
            pc_r         <= 32'h0000_0000;
        end else begin
            if (fd.branch_taken) begin
                fpc_r <= fd.branch_target;
            end else if (issue_s) begin
                fpc_r <= fpc_r + 32'd4;
            end
            if (issue_s) begin
                ipc_r <= fpc_r;
            end

            // A return the slot cannot take parks in the skid; the skid always drains first
            if (fd.branch_taken) begin
                skid_valid_r <= 1'b0;
            end else if (accept_s && !to_slot_s && !skid_valid_r) begin
                skid_valid_r <= 1'b1;
                skid_instr_r <= fd.imem_data;
                skid_pc_r    <= ipc_r;
            end else if (slot_free_s) begin
                skid_valid_r <= 1'b0;
            end

            if (fd.branch_taken) begin
                valid_r <= 1'b0;
            end else if (slot_free_s) begin
                if (skid_valid_r) begin
                    valid_r <= 1'b1;
                    instr_r <= skid_instr_r;
                    pc_r    <= skid_pc_r;
                end else if (to_slot_s) begin
                    valid_r <= 1'b1;
                    instr_r <= fd.imem_data;
                    pc_r    <= ipc_r;
                end else begin
                    valid_r <= 1'b0;
                end
            end
        end
    end

    assign fd.imem_req      = issue_s;
    assign fd.imem_addr     = issue_s ? fpc_r : 32'h0000_0000;
    assign fd.valid         = valid_r;
    assign fd.pc            = pc_r;
    assign fd.instr         = instr_r;
    assign fd.opcode        = instr_r[31:28];
    assign fd.imm           = instr_r[19:0];
    assign fd.extend_select = (instr_r[31:30] == 2'b10);

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt_r;
    logic [15:0] flush_cnt_r;

    // Saturating stall and flush event counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_r <= 16'h0000;
            flush_cnt_r <= 16'h0000;
        end else begin
            if (valid_r && fd.stall && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end
            if (fd.branch_taken && (flush_cnt_r != 16'hFFFF)) begin
                flush_cnt_r <= flush_cnt_r + 16'd1;
            end
        end
    end

    assign fd.stall_cnt = stall_cnt_r;
    assign fd.flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Scoreboard bench for fetch_decode_stage: directed phases with a behavioural instruction memory.
// Request addresses and consumed slot contents are checked by a negedge monitor against queues.
module tb_fetch_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } slot_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [31:0] req_q[$];
    slot_t       slot_q[$];

    int          lat;
    logic        mem_busy;
    int          mem_wait;
    logic [31:0] mem_addr;
    logic        inject_stale;

    fetch_decode_stage_if ifc();

    fetch_decode_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .fd  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h800F_FFFF;
        if (a == 32'h0000_0014) return 32'h300A_BCDE;
        return a + 32'h0000_0100;
    endfunction

    // one clock cycle: present memory return, capture any request, advance to posedge+1
    task automatic step();
        if (inject_stale) begin
            ifc.imem_valid = 1'b1;
            ifc.imem_data  = 32'hDEAD_BEEF;
            inject_stale   = 1'b0;
        end else if (mem_busy && mem_wait == 0) begin
            ifc.imem_valid = 1'b1;
            ifc.imem_data  = mem_word(mem_addr);
            mem_busy       = 1'b0;
        end else begin
            ifc.imem_valid = 1'b0;
            ifc.imem_data  = 32'h0000_0000;
            if (mem_busy) mem_wait--;
        end
        #1;
        if (ifc.imem_req) begin
            mem_busy = 1'b1;
            mem_addr = ifc.imem_addr;
            mem_wait = lat - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_slot(input logic [31:0] pc, input logic [31:0] instr);
        slot_t s;
        s.pc    = pc;
        s.instr = instr;
        slot_q.push_back(s);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_valid", 32'(ifc.valid), 32'h0);
        chk("rst_pc", ifc.pc, 32'h0);
        chk("rst_instr", ifc.instr, 32'h0);
        chk("rst_opcode", 32'(ifc.opcode), 32'h0);
        chk("rst_imm", 32'(ifc.imm), 32'h0);
        chk("rst_ext", 32'(ifc.extend_select), 32'h0);
    endtask

    // monitor: every request and every consumed slot instruction is matched against the queues
    always @(negedge clk) begin
        if (ifc.imem_req === 1'b1) begin
            if (req_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL req_unexpected got addr=%h expected no request", ifc.imem_addr);
            end else begin
                chk("req_addr", ifc.imem_addr, req_q.pop_front());
            end
        end
        if (ifc.valid === 1'b1 && ifc.stall === 1'b0 && ifc.branch_taken === 1'b0) begin
            if (slot_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL slot_unexpected got pc=%h instr=%h expected none", ifc.pc, ifc.instr);
            end else begin
                slot_t e;
                e = slot_q.pop_front();
                chk("slot_pc", ifc.pc, e.pc);
                chk("slot_instr", ifc.instr, e.instr);
                chk("slot_opcode", 32'(ifc.opcode), 32'(e.instr[31:28]));
                chk("slot_imm", 32'(ifc.imm), 32'(e.instr[19:0]));
                chk("slot_ext", 32'(ifc.extend_select), 32'(e.instr[31:30] == 2'b10));
            end
        end
    end

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        ifc.stall = 1'b0;
        ifc.branch_taken = 1'b0;
        ifc.branch_target = 32'h0;
        ifc.imem_valid = 1'b0;
        ifc.imem_data = 32'h0;
        lat = 1;
        mem_busy = 1'b0;
        mem_wait = 0;
        mem_addr = 32'h0;
        inject_stale = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        chk("rst_req", 32'(ifc.imem_req), 32'h0);
        chk("rst_addr", ifc.imem_addr, 32'h0);

        // streaming with 1-cycle memory, then a 3-cycle stall that fills the skid
        req_q = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18};
        push_slot(32'h00, 32'h100);
        push_slot(32'h04, 32'h104);
        push_slot(32'h08, 32'h108);
        push_slot(32'h0C, 32'h10C);
        push_slot(32'h10, 32'h800F_FFFF);
        push_slot(32'h14, 32'h300A_BCDE);
        rst = 1'b1;
        step();
        step();
        chk("first_valid", 32'(ifc.valid), 32'h1);
        chk("first_pc", ifc.pc, 32'h0);
        chk("first_instr", ifc.instr, 32'h100);
        repeat (4) step();
        chk("dec8_opcode", 32'(ifc.opcode), 32'h8);
        chk("dec8_ext", 32'(ifc.extend_select), 32'h1);
        chk("dec8_imm", 32'(ifc.imm), 32'hFFFFF);
        ifc.stall = 1'b1;
        repeat (3) step();
        chk("stall_valid", 32'(ifc.valid), 32'h1);
        chk("stall_pc", ifc.pc, 32'h10);
        chk("stall_instr", ifc.instr, 32'h800F_FFFF);
        ifc.stall = 1'b0;
        step();
        chk("skid_pc", ifc.pc, 32'h14);
        chk("dec3_opcode", 32'(ifc.opcode), 32'h3);
        chk("dec3_ext", 32'(ifc.extend_select), 32'h0);
        chk("dec3_imm", 32'(ifc.imm), 32'hABCDE);
        step();
        chk("bubble_valid", 32'(ifc.valid), 32'h0);
        rst = 1'b0;
        repeat (2) step();
        chk_reset_outputs();

        // reset while a request is outstanding, stale strobe right after release
        req_q = '{32'h00, 32'h00, 32'h04, 32'h08};
        push_slot(32'h00, 32'h100);
        push_slot(32'h04, 32'h104);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (2) step();
        inject_stale = 1'b1;
        rst = 1'b1;
        step();
        step();
        chk("stale_valid", 32'(ifc.valid), 32'h1);
        chk("stale_instr", ifc.instr, 32'h100);
        step();
        rst = 1'b0;
        repeat (2) step();

        // 3-cycle memory: redirect during an outstanding request, then flush with stall
        lat = 3;
        req_q = '{32'h00, 32'h40, 32'h44, 32'h48, 32'h80, 32'h84};
        push_slot(32'h40, 32'h140);
        push_slot(32'h80, 32'h180);
        rst = 1'b1;
        step();
`ifdef FETCH_PERF_CNT_EN
        chk("cnt_rst_flush", 32'(ifc.flush_cnt), 32'h0);
        chk("cnt_rst_stall", 32'(ifc.stall_cnt), 32'h0);
`endif
        ifc.branch_taken = 1'b1;
        ifc.branch_target = 32'h40;
        step();
        ifc.branch_taken = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("drain_valid", 32'(ifc.valid), 32'h0);
            step();
        end
        chk("redir_valid", 32'(ifc.valid), 32'h1);
        chk("redir_pc", ifc.pc, 32'h40);
        chk("redir_instr", ifc.instr, 32'h140);
        repeat (3) step();
        ifc.stall = 1'b1;
        repeat (3) step();
        chk("hold_valid", 32'(ifc.valid), 32'h1);
        chk("hold_pc", ifc.pc, 32'h44);
        ifc.branch_taken = 1'b1;
        ifc.branch_target = 32'h80;
        step();
        ifc.branch_taken = 1'b0;
        ifc.stall = 1'b0;
        chk("flush_valid", 32'(ifc.valid), 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("cnt_flush", 32'(ifc.flush_cnt), 32'h2);
        chk("cnt_stall", 32'(ifc.stall_cnt), 32'h4);
`endif
        repeat (4) step();
        chk("flush_tgt_pc", ifc.pc, 32'h80);
        chk("flush_tgt_instr", ifc.instr, 32'h180);
        step();
        rst = 1'b0;
        repeat (4) step();

        chk("req_q_left", 32'(req_q.size()), 32'h0);
        chk("slot_q_left", 32'(slot_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
